uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised, FIFO-buffered UART transmitter for the HOKSTER peripheral bus. The CPU pushes several characters through a memory-mapped data address, then issues a start command. The block drains the FIFO back-to-back and raises an interrupt when the queue is empty or a push was dropped. Frame format (data bits, parity, stop bits) and the baud divisor are set at elaboration time.

## Interface
- `DATA_BITS`, 8: character width, legal values 5..8. Only `txdata_in[DATA_BITS-1:0]` is used.
- `FIFO_DEPTH`, 4: number of FIFO entries, power of two, at least 2.
- `CLKS_PER_BIT`, 868: clock cycles per serial bit, at least 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `ADDR_START`, 16'h0110: start-command address.
- `ADDR_DATA`, 16'h0111: FIFO push address.

Ports (name, direction, width, meaning):
- `clk`, in, 1: the block's only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `addr`, in, 16: CPU address bus.
- `txdata_in`, in, 8: write data, sampled on a push.
- `ack`, in, 1: interrupt acknowledge; clears `done` and `ovf`.
- `irq`, out, 1: equals `done | ovf`.
- `txout`, out, 1: serial line, idles high.
- `busy`, out, 1: high while a frame is being shifted out.
- `full`, out, 1: FIFO is full.
- `empty`, out, 1: FIFO is empty.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.

## Operation
- **Address decode is edge-based.** `addr` is registered as `addr_q`. A command fires on a cycle where `addr` equals the command address and `addr_q` does not. Holding `addr` on a command address fires it only once.
- **Push** (`ADDR_DATA` fires):
  - If not full, `txdata_in[DATA_BITS-1:0]` is written at the write pointer.
  - If full, the write is dropped and sticky `ovf` is set.
- **Simultaneous push and pop while full:** the pop frees a slot, so the push is accepted and `fifo_count` is unchanged.
- **Pop on empty:** never happens. Pops are gated by `!empty` as sampled in the same cycle. There is no bypass from push to pop.
- **Pointers** wrap modulo `FIFO_DEPTH`. `fifo_count` is incremented or decremented separately.
- **Start** (`ADDR_START` fires) sets `tx_en`. A start while `tx_en` is already 1 has no effect.
- **State machine** (states IDLE, START, DATA, PARITY, STOP). A bit counter counts data and stop bits, and a baud counter runs 0..`CLKS_PER_BIT`-1.
  - IDLE, with `tx_en` and `!empty`: pop; load the shift register with the character; clear the parity accumulator to `PARITY_ODD`; go to START.
  - IDLE, with `tx_en` and `empty`: clear `tx_en`, set `done`, stay in IDLE.
  - START: `txout`=0 for one bit time, then go to DATA.
  - DATA: `txout` = shift register bit 0 (LSB first). Shift right at the end of each bit and XOR the sent bit into the parity accumulator. After `DATA_BITS` bits, go to PARITY if `PARITY_EN`, otherwise STOP.
  - PARITY: `txout` = parity accumulator for one bit time.
  - STOP: `txout`=1 for `STOP_BITS` bit times. In the last cycle of the last stop bit:
    - if `tx_en` and `!empty`: pop and go directly to START, with no idle gap;
    - otherwise go to IDLE.
- **Interrupt flags.** `done` and `ovf` are cleared by `ack`. If a set and `ack` occur in the same cycle, the set wins.
- **`busy`** = (state != IDLE).

## Timing
- **Reset values:** `txout`=1, `irq`=0, `busy`=0, `empty`=1, `full`=0, `fifo_count`=0, `tx_en`=0, `done`=0, `ovf`=0, state IDLE, `addr_q`=0.
- **Reset mid-frame** aborts the frame. `txout` is 1 on the cycle after `rst`, and the FIFO contents are discarded.
- **Outputs:** `txout`, `busy` and the FIFO flags are registered. `irq` is a function of registered flags only.
- **Push latency:** `fifo_count`, `empty` and `full` update one cycle after the edge-detected push.
- **Start latency:**
  - Start fires in cycle N, so `tx_en`=1 in N+1.
  - The pop happens in N+1.
  - `txout` goes low in N+2 and `busy` goes high in N+2.
- **Bit time:** each bit lasts exactly `CLKS_PER_BIT` cycles.
- **Frame length:** (1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles. Back-to-back frames have no gap.
- **Done latency:** `done` rises 2 cycles after the final stop bit ends (one cycle to enter IDLE, one to observe `empty`).
- **Empty-FIFO start:** a start with an empty FIFO gives `done`=1 in cycle N+2, with no frame sent.

## Test plan
- Reset check with `CLKS_PER_BIT`=4 and defaults:
  - Stimulus: hold `rst`=1, then release it.
  - Required response: `txout`=1, `irq`=0, `fifo_count`=0, `empty`=1.
- Single 8N1 character:
  - Stimulus: push 8'hA5, then fire start.
  - Required response: `txout` is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop 1 for 4 cycles.
  - `done`/`irq` rise 2 cycles after the stop bit, and `ack` clears them.
- Back-to-back frames:
  - Stimulus: push 8'h00 and 8'hFF, then fire start.
  - Required response: two 40-cycle frames with no idle cycle between them; `fifo_count` steps 2→1→0.
- Overflow:
  - Stimulus: with `FIFO_DEPTH`=4, push 5 characters without starting.
  - Required response: `full`=1, `ovf`/`irq`=1, and only the first 4 characters are transmitted after start.
  - Extra check: holding `addr`=`ADDR_DATA` for 10 cycles pushes only once.
- Parity and stop-bit variants:
  - Stimulus: `DATA_BITS`=7, `PARITY_EN`=1, `PARITY_ODD`=1, `STOP_BITS`=2; send 7'h03.
  - Required response: the parity bit is 1, two stop bits are sent, and the frame length is 11×4 = 44 cycles.
- Reset mid-frame:
  - Stimulus: assert `rst` during the DATA state.
  - Required response: `txout`=1 and `busy`=0 the next cycle, `fifo_count`=0, and no further frame is sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter for the HOKSTER peripheral bus.
// The CPU pushes characters at ADDR_DATA and then fires ADDR_START. The block
// drains the FIFO as back-to-back frames. It raises irq when the queue has run
// dry after a start (done), or when a push was dropped (ovf).
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   addr          - CPU address bus; commands fire on an address change
//   txdata_in     - push data; only bits [DATA_BITS-1:0] are stored
//   ack           - clears the done and ovf interrupt flags
//   irq           - done | ovf
//   txout         - serial line, idles high
//   busy          - a frame is being shifted out
//   full, empty   - FIFO status flags
//   fifo_count    - number of occupied FIFO entries
module uart_tx_fifo #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter logic [15:0] ADDR_START   = 16'h0110,
   parameter logic [15:0] ADDR_DATA    = 16'h0111
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [15:0]                   addr,
   input  logic [7:0]                    txdata_in,
   input  logic                          ack,
   output logic                          irq,
   output logic                          txout,
   output logic                          busy,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = 3;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                 state;
   logic [15:0]            addr_q;
   logic                   tx_en;
   logic                   done;
   logic                   ovf;
   logic [BAUD_W-1:0]      baud_cnt;
   logic [BIT_W-1:0]       bit_cnt;
   logic [DATA_BITS-1:0]   shreg;
   logic                   par;

   logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wptr;
   logic [PTR_W-1:0]       rptr;

   logic                   push_c;
   logic                   start_c;
   logic                   baud_last_c;
   logic                   stop_last_c;
   logic                   pop_c;
   logic                   push_ok_c;
   logic [CNT_W-1:0]       count_next_c;

   // Bits above DATA_BITS are ignored by design.
   logic                   unused_txdata;
   assign unused_txdata = ^txdata_in;

   // Commands fire only on the cycle the address arrives.
   assign push_c  = (addr == ADDR_DATA)  && (addr_q != ADDR_DATA);
   assign start_c = (addr == ADDR_START) && (addr_q != ADDR_START);

   assign baud_last_c = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
   assign stop_last_c = (state == STOP) && baud_last_c &&
                        (bit_cnt == BIT_W'(STOP_BITS - 1));

   // Pop from IDLE or straight out of the last stop bit, gated by registered empty.
   assign pop_c = tx_en && !empty && ((state == IDLE) || stop_last_c);

   // A simultaneous pop frees a slot, so a push into a full FIFO is accepted.
   assign push_ok_c = push_c && (!full || pop_c);

   assign irq = done | ovf;

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_next_c = fifo_count;
      if (push_ok_c && !pop_c) begin
         count_next_c = fifo_count + CNT_W'(1);
      end else if (pop_c && !push_ok_c) begin
         count_next_c = fifo_count - CNT_W'(1);
      end
   end

   // Address history for edge-based decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= 16'h0000;
      end else begin
         addr_q <= addr;
      end
   end

   // FIFO storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem[wptr] <= txdata_in[DATA_BITS-1:0];
      end
   end

   // FIFO pointers, occupancy, status flags and the overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
         empty      <= 1'b1;
         full       <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         if (push_ok_c) begin
            wptr <= wptr + PTR_W'(1);
         end
         if (pop_c) begin
            rptr <= rptr + PTR_W'(1);
         end
         fifo_count <= count_next_c;
         empty      <= (count_next_c == '0);
         full       <= (count_next_c == CNT_W'(FIFO_DEPTH));
         // A set in the same cycle as ack wins.
         if (push_c && !push_ok_c) begin
            ovf <= 1'b1;
         end else if (ack) begin
            ovf <= 1'b0;
         end
      end
   end

   // Transmit state machine with registered txout and busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tx_en    <= 1'b0;
         done     <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par      <= 1'b0;
         txout    <= 1'b1;
         busy     <= 1'b0;
      end else begin
         if (start_c) begin
            tx_en <= 1'b1;
         end
         if (ack) begin
            done <= 1'b0;
         end

         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               txout    <= 1'b1;
               busy     <= 1'b0;
               if (pop_c) begin
                  shreg <= mem[rptr];
                  par   <= 1'(PARITY_ODD);
                  txout <= 1'b0;
                  busy  <= 1'b1;
                  state <= START;
               end else if (tx_en) begin
                  // Queue drained: finish the run and signal completion.
                  tx_en <= 1'b0;
                  done  <= 1'b1;
               end
            end

            START: begin
               if (baud_last_c) begin
                  baud_cnt <= '0;
                  txout    <= shreg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            DATA: begin
               if (baud_last_c) begin
                  baud_cnt <= '0;
                  shreg    <= {1'b0, shreg[DATA_BITS-1:1]};
                  par      <= par ^ shreg[0];
                  if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        txout <= par ^ shreg[0];
                        state <= PARITY;
                     end else begin
                        txout <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     txout   <= shreg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            PARITY: begin
               if (baud_last_c) begin
                  baud_cnt <= '0;
                  txout    <= 1'b1;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            STOP: begin
               if (baud_last_c) begin
                  baud_cnt <= '0;
                  if (stop_last_c) begin
                     bit_cnt <= '0;
                     if (pop_c) begin
                        // Next character follows with no idle gap.
                        shreg <= mem[rptr];
                        par   <= 1'(PARITY_ODD);
                        txout <= 1'b0;
                        state <= START;
                     end else begin
                        txout <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            default: begin
               txout <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: a queue/frame-vector reference model is
// compared every cycle against an 8N1 instance; directed literal checks pin
// the model and a second 7O2 instance.
module tb_uart_tx_fifo;

   localparam int unsigned CPB    = 4;
   localparam int unsigned DEPTH  = 4;
   localparam int          FLEN   = 10 * CPB;
   localparam logic [15:0] A_START = 16'h0110;
   localparam logic [15:0] A_DATA  = 16'h0111;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr;
   logic [7:0]  txdata;
   logic        ack;
   logic        irq, txout, busy, full, empty;
   logic [2:0]  fifo_count;

   logic [15:0] addr_b;
   logic [7:0]  txdata_b;
   logic        irq_b, txout_b, busy_b, full_b, empty_b;
   logic [2:0]  count_b;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB),
                  .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1),
                  .ADDR_START(A_START), .ADDR_DATA(A_DATA)) dut (
      .clk(clk), .rst(rst), .addr(addr), .txdata_in(txdata), .ack(ack),
      .irq(irq), .txout(txout), .busy(busy), .full(full), .empty(empty),
      .fifo_count(fifo_count));

   uart_tx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB),
                  .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2),
                  .ADDR_START(A_START), .ADDR_DATA(A_DATA)) dut_b (
      .clk(clk), .rst(rst), .addr(addr_b), .txdata_in(txdata_b), .ack(1'b0),
      .irq(irq_b), .txout(txout_b), .busy(busy_b), .full(full_b), .empty(empty_b),
      .fifo_count(count_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (8N1 instance) ----------------
   logic [7:0]  m_q[$];
   bit          m_en = 0, m_done = 0, m_ovf = 0;
   logic [15:0] m_addrq = 16'h0;
   int          m_pos = -1;
   logic [15:0] m_frame = '1;

   // Frame as a bit vector, element 0 sent first: start, data LSB first, stop.
   function automatic logic [15:0] make_frame(input logic [7:0] ch);
      logic [15:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = ch[i];
      return f;
   endfunction

   always @(posedge clk) begin
      bit push_f, start_f, sending, fend, do_pop, idle_done, drop;
      if (rst) begin
         m_q.delete();
         m_en = 0; m_done = 0; m_ovf = 0; m_addrq = 16'h0; m_pos = -1;
      end else begin
         push_f    = (addr == A_DATA)  && (m_addrq != A_DATA);
         start_f   = (addr == A_START) && (m_addrq != A_START);
         sending   = (m_pos >= 0);
         fend      = sending && (m_pos == FLEN - 1);
         do_pop    = m_en && (m_q.size() != 0) && (!sending || fend);
         idle_done = m_en && (m_q.size() == 0) && !sending;
         drop      = 0;
         if (do_pop) begin
            m_frame = make_frame(m_q.pop_front());
            m_pos = 0;
         end else if (fend) m_pos = -1;
         else if (sending) m_pos++;
         if (push_f) begin
            if (m_q.size() < DEPTH) m_q.push_back(txdata);
            else drop = 1;
         end
         if (idle_done) m_en = 0;
         else if (start_f) m_en = 1;
         if (idle_done) m_done = 1;
         else if (ack) m_done = 0;
         if (drop) m_ovf = 1;
         else if (ack) m_ovf = 0;
         m_addrq = addr;
      end
   end

   // Per-cycle comparison of the 8N1 instance against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_tx;
         exp_tx = (m_pos < 0) ? 1'b1 : m_frame[m_pos / CPB];
         chk("m_txout", 32'(txout), 32'(exp_tx));
         chk("m_busy", 32'(busy), 32'(m_pos >= 0));
         chk("m_count", 32'(fifo_count), 32'(m_q.size()));
         chk("m_empty", 32'(empty), 32'(m_q.size() == 0));
         chk("m_full", 32'(full), 32'(m_q.size() == DEPTH));
         chk("m_irq", 32'(irq), 32'(m_done | m_ovf));
      end
   end

   // ---------------- drivers ----------------
   task automatic push_a(input logic [7:0] v);
      @(negedge clk); addr = A_DATA; txdata = v;
      @(negedge clk); addr = 16'h0;
   endtask

   // Fires start and leaves the bench at the negedge where txout first goes low.
   task automatic start_a();
      @(negedge clk); addr = A_START;
      @(negedge clk); addr = 16'h0;
      chk("start_lat_high", 32'(txout), 32'h1);
      @(negedge clk);
      chk("start_lat_low", 32'(txout), 32'h0);
      chk("start_busy", 32'(busy), 32'h1);
   endtask

   task automatic ack_a();
      @(negedge clk); ack = 1'b1;
      @(negedge clk); ack = 1'b0;
      chk("ack_clear", 32'(irq), 32'h0);
   endtask

   initial begin
      logic [9:0]  lit1;
      logic [19:0] lit2;
      logic [10:0] litb;
      int n;

      rst = 1'b1; addr = 16'h0; txdata = 8'h0; ack = 1'b0;
      addr_b = 16'h0; txdata_b = 8'h0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_txout", 32'(txout), 32'h1);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_count", 32'(fifo_count), 32'h0);
      chk("rst_empty", 32'(empty), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;

      // Single 8N1 character A5.
      lit1 = 10'b1_10100101_0;
      push_a(8'hA5);
      chk("push_count", 32'(fifo_count), 32'h1);
      start_a();
      chk("a5_pop_count", 32'(fifo_count), 32'h0);
      for (int i = 0; i < FLEN; i++) begin
         if (i != 0) @(negedge clk);
         chk("a5_bit", 32'(txout), 32'(lit1[i / CPB]));
      end
      @(negedge clk);
      chk("a5_idle_busy", 32'(busy), 32'h0);
      chk("a5_irq_early", 32'(irq), 32'h0);
      @(negedge clk);
      chk("a5_done", 32'(irq), 32'h1);
      ack_a();

      // Back-to-back 00 then FF.
      lit2 = {10'b1111111110, 10'b1000000000};
      push_a(8'h00);
      push_a(8'hFF);
      chk("b2b_count2", 32'(fifo_count), 32'h2);
      start_a();
      for (int i = 0; i < 2 * FLEN; i++) begin
         if (i != 0) @(negedge clk);
         chk("b2b_bit", 32'(txout), 32'(lit2[i / CPB]));
         chk("b2b_busy", 32'(busy), 32'h1);
         if (i == 0 || i == FLEN - 1) chk("b2b_count1", 32'(fifo_count), 32'h1);
         if (i == FLEN) chk("b2b_count0", 32'(fifo_count), 32'h0);
      end
      @(negedge clk);
      chk("b2b_end", 32'(busy), 32'h0);
      @(negedge clk);
      chk("b2b_done", 32'(irq), 32'h1);
      ack_a();

      // Overflow: five pushes into a four-deep FIFO.
      for (int k = 0; k < 5; k++) push_a(8'($urandom));
      chk("ovf_full", 32'(full), 32'h1);
      chk("ovf_count", 32'(fifo_count), 32'h4);
      chk("ovf_irq", 32'(irq), 32'h1);
      ack_a();
      start_a();
      n = 0;
      while (busy && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("ovf_busy_cycles", 32'(n), 32'(4 * FLEN));
      chk("ovf_irq_early", 32'(irq), 32'h0);
      @(negedge clk);
      chk("ovf_done", 32'(irq), 32'h1);
      ack_a();

      // Holding the data address pushes only once.
      @(negedge clk); addr = A_DATA; txdata = 8'h3C;
      repeat (10) @(negedge clk);
      addr = 16'h0;
      chk("hold_count", 32'(fifo_count), 32'h1);

      // Reset mid-frame.
      push_a(8'h96);
      start_a();
      repeat (12) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("midrst_txout", 32'(txout), 32'h1);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_count", 32'(fifo_count), 32'h0);
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy) n++;
      end
      chk("midrst_no_frame", 32'(n), 32'h0);

      // 7O2 instance: 7'h03 with an ignored bit 7.
      litb = 11'b11_1_0000011_0;
      @(negedge clk); addr_b = A_DATA; txdata_b = 8'h83;
      @(negedge clk); addr_b = 16'h0;
      chk("b_count", 32'(count_b), 32'h1);
      chk("b_empty", 32'(empty_b), 32'h0);
      chk("b_full", 32'(full_b), 32'h0);
      @(negedge clk); addr_b = A_START;
      @(negedge clk); addr_b = 16'h0;
      chk("b_lat_high", 32'(txout_b), 32'h1);
      for (int i = 0; i < 11 * CPB; i++) begin
         @(negedge clk);
         chk("b_bit", 32'(txout_b), 32'(litb[i / CPB]));
         chk("b_busy", 32'(busy_b), 32'h1);
      end
      @(negedge clk);
      chk("b_len", 32'(busy_b), 32'h0);
      chk("b_irq_early", 32'(irq_b), 32'h0);
      @(negedge clk);
      chk("b_done", 32'(irq_b), 32'h1);

      // Randomised traffic checked by the model.
      for (int c = 0; c < 4000; c++) begin
         int r;
         @(negedge clk);
         rst = ($urandom_range(0, 999) < 1) && !rst;
         r = $urandom_range(0, 99);
         if (r < 12) addr = A_DATA;
         else if (r < 15) addr = A_START;
         else if (r < 20) addr = 16'($urandom);
         else if (r < 80) addr = addr;
         else addr = 16'h0;
         txdata = 8'($urandom);
         ack = ($urandom_range(0, 99) < 4);
      end
      @(negedge clk);
      rst = 1'b0; addr = 16'h0; ack = 1'b0;
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
